// File: rtl/apb_seq_cpu.sv
// apb_seq_cpu -- parametrised command-sequencer CPU for the APB peripheral
// subsystem. Fetches instruction words from a program memory with one cycle
// of read latency and dispatches WRITE/READ commands to the APB master. Adds
// read-data capture, JUMP, a counted loop (SETCNT/DJNZ), transfer timeout,
// slave-error detection and an error code.
//
// Ports:
//   CCLK, CPURESET        clock, asynchronous active-high reset
//   RUN                   level, allows instruction fetch (pause/resume)
//   imem_en/imem_addr     program memory read request (one cycle, in FETCH)
//   imem_rdata            instruction word, valid the cycle after imem_en
//   APBMASTERENABLE       transfer request to the APB master
//   CPUSEL/addr/data/wr   one-hot select, address, write data, direction
//   CPUPREADY/rdata/slverr transfer completion, read data, slave error
//   last_rdata            data of the most recent completed READ
//   CPUDONE               high in IDLE, HALTED and ERROR
//   err_code              0 none, 1 illegal opcode/select, 2 slave error, 3 timeout
//
// Instruction word, MSB first: opcode[3:0], sel[SEL_W-1:0],
// paddr[PADDR_W-1:0], pdata[PDATA_W-1:0].

module apb_seq_cpu #(
  parameter int NUM_PERIPH = 4,
  parameter int PADDR_W    = 8,
  parameter int PDATA_W    = 32,
  parameter int PC_W       = 8,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255,
  localparam int SEL_W     = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1,
  localparam int INSTR_W   = 4 + SEL_W + PADDR_W + PDATA_W
) (
  input  logic                  CCLK,
  input  logic                  CPURESET,
  input  logic                  RUN,
  output logic                  imem_en,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]    imem_rdata,
  output logic                  APBMASTERENABLE,
  output logic [NUM_PERIPH-1:0] CPUSEL,
  output logic [PADDR_W-1:0]    addr,
  output logic [PDATA_W-1:0]    data,
  output logic                  wr,
  input  logic                  CPUPREADY,
  input  logic [PDATA_W-1:0]    rdata,
  input  logic                  slverr,
  output logic [PDATA_W-1:0]    last_rdata,
  output logic                  CPUDONE,
  output logic [1:0]            err_code
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_WRITE  = 4'd1;
  localparam logic [3:0] OP_READ   = 4'd2;
  localparam logic [3:0] OP_JUMP   = 4'd3;
  localparam logic [3:0] OP_SETCNT = 4'd4;
  localparam logic [3:0] OP_DJNZ   = 4'd5;
  localparam logic [3:0] OP_HALT   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ACCESS, S_HALTED, S_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc;
  logic [CNT_W-1:0]     cnt;
  logic [INSTR_W-1:0]   ir;
  logic [TO_W-1:0]      tcnt;

  logic [3:0]           ir_op;
  logic [SEL_W-1:0]     ir_sel;
  logic [PADDR_W-1:0]   ir_paddr;
  logic [PDATA_W-1:0]   ir_pdata;
  logic                 sel_ok;
  logic                 is_xfer;
  logic                 timeout_hit;

  assign ir_op    = ir[INSTR_W-1 -: 4];
  assign ir_sel   = ir[PADDR_W+PDATA_W +: SEL_W];
  assign ir_paddr = ir[PDATA_W +: PADDR_W];
  assign ir_pdata = ir[PDATA_W-1:0];

  // A select field can encode more peripherals than exist when NUM_PERIPH
  // is not a power of two; those encodings are treated as illegal.
  assign sel_ok      = (32'(ir_sel) < 32'(NUM_PERIPH));
  assign is_xfer     = (ir_op == OP_WRITE) || (ir_op == OP_READ);
  // Fires on the TIMEOUT-th ACCESS cycle without CPUPREADY.
  assign timeout_hit = (tcnt == TO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge CCLK or posedge CPURESET) begin
    if (CPURESET) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (RUN) state_d = S_FETCH;
      S_FETCH:  state_d = RUN ? S_DECODE : S_IDLE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (ir_op)
          OP_NOP, OP_JUMP, OP_SETCNT, OP_DJNZ: state_d = S_FETCH;
          OP_WRITE, OP_READ: state_d = sel_ok ? S_ACCESS : S_ERROR;
          OP_HALT:  state_d = S_HALTED;
          default:  state_d = S_ERROR;
        endcase
      end
      S_ACCESS: begin
        if (CPUPREADY)        state_d = slverr ? S_ERROR : S_FETCH;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    imem_en   = (state_q == S_FETCH) && RUN;
    imem_addr = pc;
    CPUDONE   = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR);
  end

  // Program counter, loop counter, instruction register and transfer outputs
  always_ff @(posedge CCLK or posedge CPURESET) begin
    if (CPURESET) begin
      pc              <= '0;
      cnt             <= '0;
      ir              <= '0;
      tcnt            <= '0;
      APBMASTERENABLE <= 1'b0;
      CPUSEL          <= '0;
      addr            <= '0;
      data            <= '0;
      wr              <= 1'b0;
      last_rdata      <= '0;
      err_code        <= 2'd0;
    end else begin
      case (state_q)
        S_DECODE: ir <= imem_rdata;
        S_EXEC: begin
          case (ir_op)
            OP_NOP:    pc <= pc + 1'b1;
            OP_JUMP:   pc <= ir_pdata[PC_W-1:0];
            OP_SETCNT: begin
              cnt <= ir_pdata[CNT_W-1:0];
              pc  <= pc + 1'b1;
            end
            OP_DJNZ: begin
              // A zero count falls through without wrapping the counter.
              if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                pc  <= ir_pdata[PC_W-1:0];
              end else begin
                pc  <= pc + 1'b1;
              end
            end
            OP_WRITE, OP_READ: begin
              if (sel_ok) begin
                CPUSEL          <= NUM_PERIPH'(1) << ir_sel;
                addr            <= ir_paddr;
                data            <= ir_pdata;
                wr              <= (ir_op == OP_WRITE);
                APBMASTERENABLE <= 1'b1;
                tcnt            <= '0;
              end else begin
                err_code <= 2'd1;
              end
            end
            OP_HALT: ;
            default: err_code <= 2'd1;
          endcase
        end
        S_ACCESS: begin
          if (CPUPREADY) begin
            APBMASTERENABLE <= 1'b0;
            CPUSEL          <= '0;
            pc              <= pc + 1'b1;
            if (!wr)    last_rdata <= rdata;
            if (slverr) err_code   <= 2'd2;
          end else if (timeout_hit) begin
            APBMASTERENABLE <= 1'b0;
            CPUSEL          <= '0;
            err_code        <= 2'd3;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
